// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: multi-cycle, cascadable magnitude comparator. Compares one SLICE-bit slice per clock, MSB slice first, and stops at the first unequal slice.
// Optional feature macro: SEQ_MAG_CMP_SIGNED_EN adds the signed_mode port (two's-complement ordering).
module seq_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq_in,
  input  logic             gt_in,
`ifdef SEQ_MAG_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_l, b_l, a_nxt, b_nxt, msb_flip;
  logic             eq_in_l, gt_in_l, eq_in_nxt, gt_in_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic             eq_nxt, gt_nxt, lt_nxt;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [1:0]       sl_res;

  // Returns {x greater than y, x less than y} for one unsigned slice.
  function automatic logic [1:0] slice_cmp(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y);
    slice_cmp = {(x > y), (x < y)};
  endfunction

  assign a_sl   = a_l[int'(idx) * SLICE +: SLICE];
  assign b_sl   = b_l[int'(idx) * SLICE +: SLICE];
  assign sl_res = slice_cmp(a_sl, b_sl);

  // Signed ordering is obtained by flipping the sign bit of both operands at latch time.
  always_comb begin
    msb_flip = '0;
`ifdef SEQ_MAG_CMP_SIGNED_EN
    msb_flip[WIDTH-1] = signed_mode;
`else
    msb_flip[WIDTH-1] = 1'b0;
`endif
  end

  // Next-state, operand latch and result computation.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_nxt     = a_l;
    b_nxt     = b_l;
    eq_in_nxt = eq_in_l;
    gt_in_nxt = gt_in_l;
    eq_nxt    = EQ;
    gt_nxt    = GT;
    lt_nxt    = LT;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = IDX_TOP;
          a_nxt     = a ^ msb_flip;
          b_nxt     = b ^ msb_flip;
          eq_in_nxt = eq_in;
          gt_in_nxt = gt_in;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (sl_res[1]) begin
          state_nxt = DONE;
          eq_nxt    = 1'b0;
          gt_nxt    = 1'b1;
          lt_nxt    = 1'b0;
        end else if (sl_res[0]) begin
          state_nxt = DONE;
          eq_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b1;
        end else if (idx != '0) begin
          idx_nxt = idx - IDXW'(1);
        end else begin
          // Operands fully equal: the less-significant stage decides.
          state_nxt = DONE;
          eq_nxt    = eq_in_l;
          gt_nxt    = gt_in_l & ~eq_in_l;
          lt_nxt    = ~eq_in_l & ~gt_in_l;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_l     <= '0;
      b_l     <= '0;
      eq_in_l <= 1'b0;
      gt_in_l <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      EQ      <= 1'b0;
      GT      <= 1'b0;
      LT      <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      a_l     <= a_nxt;
      b_l     <= b_nxt;
      eq_in_l <= eq_in_nxt;
      gt_in_l <= gt_in_nxt;
      busy    <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      EQ      <= eq_nxt;
      GT      <= gt_nxt;
      LT      <= lt_nxt;
    end
  end

endmodule

// File: doc/seq_mag_cmp.md
# seq_mag_cmp

Parametrised, multi-cycle, cascadable magnitude comparator. It is the next generation of the team's 8-bit cascade comparator (`cmp8`). It compares two WIDTH-bit operands one SLICE-bit slice per clock, most-significant slice first. It terminates early on the first unequal slice and resolves full equality through the same eq/gt cascade inputs as `cmp8`. It sits in datapaths that need wide compares without a wide combinational chain, under a start/done handshake.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SLICE.
- SLICE, 4, bits compared per cycle; NSLICE = WIDTH/SLICE, and NSLICE ≥ 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge in IDLE or DONE.
- a  in  WIDTH  operand A; latched on an accepted start.
- b  in  WIDTH  operand B; latched on an accepted start.
- eq_in  in  1  cascade equal-in from a less-significant stage; latched on start.
- gt_in  in  1  cascade greater-in; latched on start.
- signed_mode  in  1  latched on start. Present only with SEQ_MAG_CMP_SIGNED_EN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a result becomes valid.
- EQ  out  1  result: A equals B, qualified by the cascade.
- GT  out  1  result: A greater than B.
- LT  out  1  result: A less than B.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1:
  - latch a, b, eq_in and gt_in (and signed_mode if compiled in);
  - set slice index idx=NSLICE-1;
  - go to RUN.
  - Outputs EQ/GT/LT keep their previous values until the new result is written.
- RUN, one slice per cycle. Compare slice a[idx*SLICE +: SLICE] against the matching b slice as unsigned values:
  - A slice > B slice: GT=1, EQ=0, LT=0, go to DONE.
  - A slice < B slice: LT=1, EQ=0, GT=0, go to DONE.
  - Slices equal and idx>0: decrement idx, stay in RUN.
  - Slices equal and idx==0 (full equality):
    - EQ=eq_in_l;
    - GT=gt_in_l & ~eq_in_l;
    - LT=~eq_in_l & ~gt_in_l;
    - go to DONE.
- DONE: done=1 for exactly this cycle. Then return to IDLE, or go to RUN if start=1.
- start in RUN is ignored; there is no queuing.
- Exactly one of EQ/GT/LT is high after any completed compare. All three are 0 only after reset and before the first result.
- EQ/GT/LT hold their value until the next result is written.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, EQ=0, GT=0, LT=0, idx=0, state IDLE.
- Start accepted at rising edge 0 gives the following:
  - busy is high from edge 0.
  - The deciding slice is evaluated in cycle k, 1 ≤ k ≤ NSLICE.
  - Results update at edge k. done is high between edges k and k+1. busy drops at edge k.
  - Minimum latency is 1 cycle (MSB slice differs). Maximum is NSLICE cycles (equal operands, or a difference only in slice 0).
- Back-to-back: a start during the DONE cycle is accepted. The new compare begins at the next edge with no idle bubble.
- Reset mid-operation (rst_n low in any state) immediately clears all outputs and state. No done is produced for the aborted compare.
- Operand or cascade input changes after the start edge have no effect on the compare in flight.

## Configuration
- SEQ_MAG_CMP_SIGNED_EN defined:
  - the signed_mode port exists.
  - With signed_mode_l=1, the MSB of the top slice (bit WIDTH-1) of both operands is inverted before comparing. This gives a two's-complement ordering.
  - Lower slices and the cascade behave unchanged.
- SEQ_MAG_CMP_SIGNED_EN not defined: the port is absent and all compares are unsigned.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
1. a=0x1234, b=0x1234, eq_in=1, gt_in=0, start -> done 4 cycles later; EQ=1, GT=0, LT=0. Same operands with eq_in=0, gt_in=1 -> GT=1 after 4 cycles.
2. a=0x0001, b=0x0000, eq_in=0, gt_in=1 -> done 4 cycles later, GT=1. Then a=0x0000, eq_in=1, gt_in=0 -> EQ=1 after 4 cycles, with GT falling at the same edge.
3. a=0x8000, b=0x7FFF unsigned -> done 1 cycle after start, GT=1. With SEQ_MAG_CMP_SIGNED_EN and signed_mode=1 -> done 1 cycle after start, LT=1.
4. start pulsed while busy with different operands -> ignored; the first result is unaffected. start held during DONE -> second compare accepted, busy re-asserts with no gap.
5. rst_n pulsed low 2 cycles into a 4-cycle compare -> busy, done, EQ, GT and LT all 0 at once. No done pulse follows. The next start works normally.
6. Random a/b/eq_in/gt_in, 1000 compares -> each result matches a reference model, and latency equals the index of the first differing slice from the MSB (NSLICE when operands are equal).
